// File: rtl/idct_block_sequencer.sv
// Single-buffered 8x8 block sequencer: loads 64 coefficients, runs one Fast_IDCT core over them, drains the result.
// Optional macro IDCT_CYCLE_COUNT_EN adds run_cycles (START+RUN cycles of the last completed block).
module idct_block_sequencer #(
    parameter int          DATA_W    = 16,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          TIMEOUT   = 4096
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              core_reset_n,
    output logic              core_start,
    input  logic              core_done,
    input  logic              core_oe,
    input  logic              core_we,
    input  logic [31:0]       core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    input  logic [4:0]        core_size,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_rdy,
    output logic              busy,
    output logic              err
`ifdef IDCT_CYCLE_COUNT_EN
    ,
    output logic [31:0]       run_cycles
`endif
);

    localparam int              WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);

    typedef enum logic [2:0] {
        S_LOAD    = 3'd0,
        S_START   = 3'd1,
        S_RUN     = 3'd2,
        S_RECOVER = 3'd3,
        S_DRAIN   = 3'd4
    } state_t;

    state_t            state_q;
    logic [5:0]        idx_q;
    logic              err_q;
    logic [WD_W-1:0]   wdog_q;
    logic              rec_q;
    logic [DATA_W-1:0] buf_q [64];

    logic [31:0]       offset_s;
    logic              in_range_s;
    logic [5:0]        cidx_s;
    logic [DATA_W-1:0] mask_s;
    logic              run_s;
    logic              rd_s;
    logic              wr_s;
    logic              acc_err_s;
    logic              buf_we_s;
    logic [5:0]        buf_widx_s;
    logic [DATA_W-1:0] buf_wdata_s;

    // Bit b of the mask is set when b < size, so any size >= DATA_W yields all ones.
    function automatic logic [DATA_W-1:0] size_mask(input logic [4:0] size);
        logic [DATA_W-1:0] m;
        m = {DATA_W{1'b0}};
        for (int b = 0; b < DATA_W; b++) begin
            m[b] = (b < int'(size)) ? 1'b1 : 1'b0;
        end
        return m;
    endfunction

    // Decode of the core's memory port; only live while the core owns the buffer.
    always_comb begin
        offset_s   = core_addr - BASE_ADDR;
        in_range_s = (offset_s < 32'd128) && (offset_s[0] == 1'b0);
        cidx_s     = offset_s[6:1];
        mask_s     = size_mask(core_size);
        run_s      = (state_q == S_RUN);
        rd_s       = run_s && core_oe && !core_we;
        wr_s       = run_s && core_we && !core_oe;
        acc_err_s  = run_s && ((core_oe && core_we) || ((core_oe != core_we) && !in_range_s));
        core_rdy   = run_s && (core_oe || core_we);
        if (rd_s && in_range_s) begin
            core_rdata = buf_q[cidx_s] & mask_s;
        end else begin
            core_rdata = {DATA_W{1'b0}};
        end
    end

    // Single write port shared by the input stream (LOAD) and the core (RUN).
    always_comb begin
        buf_we_s    = 1'b0;
        buf_widx_s  = idx_q;
        buf_wdata_s = in_data;
        if ((state_q == S_LOAD) && in_valid && !reset) begin
            buf_we_s = 1'b1;
        end else if (wr_s && in_range_s) begin
            buf_we_s    = 1'b1;
            buf_widx_s  = cidx_s;
            buf_wdata_s = core_wdata & mask_s;
        end else begin
            buf_we_s = 1'b0;
        end
    end

    // Coefficient buffer storage; contents are don't-care after reset.
    always_ff @(posedge clock) begin
        if (buf_we_s) begin
            buf_q[buf_widx_s] <= buf_wdata_s;
        end
    end

    // Block sequencing state machine with run watchdog and sticky error.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_LOAD;
            idx_q   <= 6'd0;
            err_q   <= 1'b0;
            wdog_q  <= {WD_W{1'b0}};
            rec_q   <= 1'b0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (in_valid) begin
                        if (idx_q == 6'd63) begin
                            state_q <= S_START;
                            idx_q   <= 6'd0;
                        end else begin
                            idx_q <= idx_q + 6'd1;
                        end
                    end
                end
                S_START: begin
                    wdog_q  <= {WD_W{1'b0}};
                    state_q <= S_RUN;
                end
                S_RUN: begin
                    if (acc_err_s) begin
                        err_q <= 1'b1;
                    end
                    if (core_done) begin
                        state_q <= S_DRAIN;
                        idx_q   <= 6'd0;
                    end else if (wdog_q == WD_LAST) begin
                        err_q   <= 1'b1;
                        state_q <= S_RECOVER;
                        rec_q   <= 1'b0;
                    end else begin
                        wdog_q <= wdog_q + WD_ONE;
                    end
                end
                S_RECOVER: begin
                    if (rec_q) begin
                        state_q <= S_LOAD;
                        idx_q   <= 6'd0;
                        rec_q   <= 1'b0;
                    end else begin
                        rec_q <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (out_ready) begin
                        if (idx_q == 6'd63) begin
                            state_q <= S_LOAD;
                            idx_q   <= 6'd0;
                        end else begin
                            idx_q <= idx_q + 6'd1;
                        end
                    end
                end
                default: begin
                    state_q <= S_LOAD;
                    idx_q   <= 6'd0;
                end
            endcase
        end
    end

    // Stream and core handshakes decoded from the state register.
    always_comb begin
        in_ready     = (state_q == S_LOAD) && !reset;
        out_valid    = (state_q == S_DRAIN);
        out_last     = out_valid && (idx_q == 6'd63);
        if (out_valid) begin
            out_data = buf_q[idx_q];
        end else begin
            out_data = {DATA_W{1'b0}};
        end
        core_start   = (state_q == S_START);
        core_reset_n = !reset && (state_q != S_RECOVER);
        busy         = (state_q != S_LOAD);
        err          = err_q;
    end

`ifdef IDCT_CYCLE_COUNT_EN
    logic [31:0] run_cnt_q;
    logic [31:0] run_cycles_q;

    // START counts as cycle 1; the done cycle is included when the result is latched.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            run_cnt_q    <= 32'd0;
            run_cycles_q <= 32'd0;
        end else if (state_q == S_START) begin
            run_cnt_q <= 32'd1;
        end else if (state_q == S_RUN) begin
            run_cnt_q <= run_cnt_q + 32'd1;
            if (core_done) begin
                run_cycles_q <= run_cnt_q + 32'd1;
            end
        end
    end

    assign run_cycles = run_cycles_q;
`endif

endmodule

// File: tb/tb_idct_block_sequencer.sv
// Directed bench for idct_block_sequencer; a behavioural stub plays the IDCT core on the memory port.
module tb_idct_block_sequencer;
    localparam int          DW   = 16;
    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam int          TO   = 16;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic in_valid = 1'b0, out_ready = 1'b0, core_done = 1'b0, core_oe = 1'b0, core_we = 1'b0;
    logic [DW-1:0] in_data = 16'd0, core_wdata = 16'd0;
    logic [31:0] core_addr = 32'd0;
    logic [4:0]  core_size = 5'd16;
    logic in_ready, out_valid, out_last, core_reset_n, core_start, core_rdy, busy, err;
    logic [DW-1:0] out_data, core_rdata;
`ifdef IDCT_CYCLE_COUNT_EN
    logic [31:0] run_cycles;
`endif

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] din [64];
    logic [DW-1:0] exp_v [64];
    logic [DW-1:0] got [64];
    logic          gotlast [64];
    int stall_bad, last_cnt, loaded;

    idct_block_sequencer #(.DATA_W(DW), .BASE_ADDR(BASE), .TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .core_reset_n(core_reset_n), .core_start(core_start), .core_done(core_done),
        .core_oe(core_oe), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_size(core_size), .core_rdata(core_rdata), .core_rdy(core_rdy),
        .busy(busy), .err(err)
`ifdef IDCT_CYCLE_COUNT_EN
        , .run_cycles(run_cycles)
`endif
    );

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clock);
        #2;
    endtask

    task automatic load_block(input int vper);
        int k, cyc;
        k = 0; cyc = 0;
        while (k < 64 && cyc < 1000) begin
            in_valid = ((cyc % vper) == 0);
            in_data  = din[k];
            #1;
            if (in_valid && in_ready) k++;
            tick;
            cyc++;
        end
        in_valid = 1'b0;
        loaded   = k;
    endtask

    task automatic core_access(input logic oe, input logic we, input logic [31:0] addr,
                               input logic [4:0] size, input logic [DW-1:0] wd,
                               output logic [DW-1:0] rd, output logic rdy);
        core_oe = oe; core_we = we; core_addr = addr; core_size = size; core_wdata = wd;
        #1;
        rd = core_rdata; rdy = core_rdy;
        tick;
        core_oe = 1'b0; core_we = 1'b0;
    endtask

    task automatic core_finish;
        core_done = 1'b1;
        tick;
        core_done = 1'b0;
    endtask

    task automatic drain_capture(input int rper, output int n);
        int cyc;
        logic [DW-1:0] held;
        logic stalled;
        n = 0; cyc = 0; stalled = 1'b0; held = 16'd0; stall_bad = 0; last_cnt = 0;
        while (n < 64 && cyc < 2000) begin
            out_ready = ((cyc % rper) == 0);
            #1;
            if (stalled && out_valid && (out_data !== held)) stall_bad++;
            if (out_valid && out_ready) begin
                got[n] = out_data; gotlast[n] = out_last;
                if (out_last) last_cnt++;
                n++; stalled = 1'b0;
            end else if (out_valid) begin
                stalled = 1'b1; held = out_data;
            end else begin
                stalled = 1'b0;
            end
            tick;
            cyc++;
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick; tick;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        checks++; if (core_reset_n !== 1'b0) begin errors++; $display("FAIL reset_core_rstn: got %b want 0", core_reset_n); end
        checks++; if ({busy, core_start, err, out_valid} !== 4'b0000) begin errors++; $display("FAIL reset_outputs: got %b want 0000", {busy, core_start, err, out_valid}); end
        reset = 1'b0;
        #1;
        checks++; if ({core_reset_n, in_ready} !== 2'b11) begin errors++; $display("FAIL reset_release: got %b want 11", {core_reset_n, in_ready}); end
    endtask

    task automatic test_block;
        logic [DW-1:0] rd;
        logic rdy;
        int n, bad;
        int tl [5] = '{0, 7, 31, 62, 63};
        for (int k = 0; k < 64; k++) begin
            din[k] = 16'((k * 2731) ^ 36624);
            exp_v[k] = din[k];
        end
        core_oe = 1'b1; core_we = 1'b1; core_addr = BASE + 32'h200;
        #1;
        checks++; if ({core_rdy, core_rdata} !== 17'd0) begin errors++; $display("FAIL idle_port: got rdy=%b rdata=%h want 0", core_rdy, core_rdata); end
        tick;
        core_oe = 1'b0; core_we = 1'b0;
        load_block(1);
        checks++; if (loaded !== 64) begin errors++; $display("FAIL load_count: got %0d want 64", loaded); end
        checks++; if ({core_start, busy, in_ready} !== 3'b110) begin errors++; $display("FAIL start_pulse: got %b want 110", {core_start, busy, in_ready}); end
        tick;
        checks++; if (core_start !== 1'b0) begin errors++; $display("FAIL start_one_cycle: got %b want 0", core_start); end
        for (int j = 0; j < 5; j++) begin
            core_access(1'b1, 1'b0, BASE + 32'(2 * tl[j]), 5'd16, 16'd0, rd, rdy);
            checks++; if ({rdy, rd} !== {1'b1, din[tl[j]]}) begin errors++; $display("FAIL core_read[%0d]: got %b/%h want 1/%h", tl[j], rdy, rd, din[tl[j]]); end
            core_access(1'b0, 1'b1, BASE + 32'(2 * tl[j]), 5'd16, ~din[tl[j]], rd, rdy);
            exp_v[tl[j]] = ~din[tl[j]];
        end
        core_access(1'b0, 1'b1, BASE + 32'd20, 5'd8, 16'hABCD, rd, rdy);
        exp_v[10] = 16'h00CD;
        core_access(1'b1, 1'b0, BASE + 32'd20, 5'd4, 16'd0, rd, rdy);
        checks++; if (rd !== 16'h000D) begin errors++; $display("FAIL size_mask_read: got %h want 000d", rd); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL run_no_output: got %b want 0", out_valid); end
        core_finish;
        checks++; if ({out_valid, out_data} !== {1'b1, exp_v[0]}) begin errors++; $display("FAIL done_latency: got %b/%h want 1/%h", out_valid, out_data, exp_v[0]); end
        drain_capture(1, n);
        checks++; if (n !== 64) begin errors++; $display("FAIL drain_count: got %0d want 64", n); end
        bad = 0;
        for (int k = 0; k < 64; k++) if (got[k] !== exp_v[k] || gotlast[k] !== (k == 63)) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL block_data: got %0d bad samples want 0", bad); end
        checks++; if ({in_ready, busy, err} !== 3'b100) begin errors++; $display("FAIL block_end: got %b want 100", {in_ready, busy, err}); end
    endtask

    task automatic test_back_to_back;
        int n, bad;
        for (int b = 0; b < 2; b++) begin
            for (int k = 0; k < 64; k++) din[k] = 16'd0;
            if (b == 1) din[0] = 16'd64;
            load_block(1);
            tick;
            core_finish;
            drain_capture(1, n);
            checks++; if ({in_ready, busy} !== 2'b10) begin errors++; $display("FAIL b2b_idle[%0d]: got %b want 10", b, {in_ready, busy}); end
            bad = 0;
            for (int k = 0; k < 64; k++) if (got[k] !== din[k]) bad++;
            checks++; if (n !== 64 || bad !== 0) begin errors++; $display("FAIL b2b_data[%0d]: got n=%0d bad=%0d want 64/0", b, n, bad); end
        end
    endtask

    task automatic test_stall;
        int n, bad;
        for (int k = 0; k < 64; k++) din[k] = 16'((k * 40503 + 4660) >> 3);
        load_block(2);
        tick;
        core_finish;
        drain_capture(3, n);
        bad = 0;
        for (int k = 0; k < 64; k++) if (got[k] !== din[k]) bad++;
        checks++; if (n !== 64 || bad !== 0) begin errors++; $display("FAIL stall_data: got n=%0d bad=%0d want 64/0", n, bad); end
        checks++; if (stall_bad !== 0) begin errors++; $display("FAIL stall_stable: got %0d changes want 0", stall_bad); end
        checks++; if (last_cnt !== 1) begin errors++; $display("FAIL stall_last: got %0d want 1", last_cnt); end
    endtask

    task automatic test_timeout;
        load_block(1);
        tick;
        for (int c = 0; c < 15; c++) tick;
        checks++; if ({busy, core_reset_n, err} !== 3'b110) begin errors++; $display("FAIL wdog_early: got %b want 110", {busy, core_reset_n, err}); end
        tick;
        checks++; if ({err, core_reset_n, in_ready} !== 3'b100) begin errors++; $display("FAIL wdog_fire: got %b want 100", {err, core_reset_n, in_ready}); end
        tick;
        checks++; if (core_reset_n !== 1'b0) begin errors++; $display("FAIL recover_2nd: got %b want 0", core_reset_n); end
        tick;
        checks++; if ({core_reset_n, in_ready, err} !== 3'b111) begin errors++; $display("FAIL recover_exit: got %b want 111", {core_reset_n, in_ready, err}); end
    endtask

    task automatic test_out_of_range;
        logic [DW-1:0] rd;
        logic rdy;
        int n, bad;
        reset = 1'b1; tick; reset = 1'b0; #1;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL oob_clear: got %b want 0", err); end
        for (int k = 0; k < 64; k++) din[k] = 16'(k + 256);
        load_block(1);
        tick;
        core_access(1'b0, 1'b1, BASE + 32'h80, 5'd16, 16'h1234, rd, rdy);
        checks++; if ({rdy, err} !== 2'b11) begin errors++; $display("FAIL oob_write: got rdy/err=%b want 11", {rdy, err}); end
        core_access(1'b1, 1'b0, BASE + 32'h80, 5'd16, 16'd0, rd, rdy);
        checks++; if (rd !== 16'd0) begin errors++; $display("FAIL oob_read: got %h want 0000", rd); end
        core_access(1'b1, 1'b0, BASE + 32'h3, 5'd16, 16'd0, rd, rdy);
        checks++; if (rd !== 16'd0) begin errors++; $display("FAIL odd_read: got %h want 0000", rd); end
        core_access(1'b1, 1'b0, BASE - 32'h2, 5'd16, 16'd0, rd, rdy);
        checks++; if (rd !== 16'd0) begin errors++; $display("FAIL below_base_read: got %h want 0000", rd); end
        core_finish;
        drain_capture(1, n);
        bad = 0;
        for (int k = 0; k < 64; k++) if (got[k] !== din[k]) bad++;
        checks++; if (n !== 64 || bad !== 0) begin errors++; $display("FAIL oob_buffer: got n=%0d bad=%0d want 64/0", n, bad); end
    endtask

    task automatic test_both_high;
        logic [DW-1:0] rd;
        logic rdy;
        int n;
        reset = 1'b1; tick; reset = 1'b0;
        for (int k = 0; k < 64; k++) din[k] = 16'(3 * k);
        load_block(1);
        tick;
        core_access(1'b1, 1'b1, BASE + 32'd4, 5'd16, 16'hFFFF, rd, rdy);
        checks++; if ({rdy, rd, err} !== {1'b1, 16'd0, 1'b1}) begin errors++; $display("FAIL both_high: got %b/%h/%b want 1/0000/1", rdy, rd, err); end
        core_finish;
        drain_capture(1, n);
        checks++; if (got[2] !== 16'd6) begin errors++; $display("FAIL both_high_nowrite: got %h want 0006", got[2]); end
    endtask

    task automatic test_reset_midrun;
        logic [DW-1:0] rd;
        logic rdy;
        int n, bad;
        for (int k = 0; k < 64; k++) din[k] = 16'(65535 - 5 * k);
        load_block(1);
        tick;
        core_access(1'b1, 1'b1, BASE, 5'd16, 16'd0, rd, rdy);
        for (int c = 0; c < 9; c++) tick;
        reset = 1'b1;
        #1;
        checks++; if ({core_reset_n, busy, in_ready} !== 3'b000) begin errors++; $display("FAIL midrun_reset: got %b want 000", {core_reset_n, busy, in_ready}); end
        tick;
        reset = 1'b0;
        #1;
        checks++; if ({err, in_ready, core_start, core_reset_n} !== 4'b0101) begin errors++; $display("FAIL midrun_release: got %b want 0101", {err, in_ready, core_start, core_reset_n}); end
        for (int k = 0; k < 64; k++) din[k] = 16'(k * 1000 + 7);
        load_block(1);
        tick;
        core_finish;
        drain_capture(1, n);
        bad = 0;
        for (int k = 0; k < 64; k++) if (got[k] !== din[k]) bad++;
        checks++; if (n !== 64 || bad !== 0) begin errors++; $display("FAIL midrun_fresh: got n=%0d bad=%0d want 64/0", n, bad); end
    endtask

    initial begin
        test_reset;
        test_block;
        test_back_to_back;
        test_stall;
        test_timeout;
        test_out_of_range;
        test_both_high;
        test_reset_midrun;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
